// File: rtl/leaf_rtr_pkg.sv
// Shared constants for the leaf group router: header field positions, port
// indices and the round-robin pick helper used by every output arbiter.
package leaf_rtr_pkg;

  localparam int GRP_MSB  = 15;
  localparam int GRP_LSB  = 12;
  localparam int LEAF_MSB = 11;
  localparam int LEAF_LSB = 10;

  localparam int LEAF0     = 0;
  localparam int LEAF1     = 1;
  localparam int LEAF2     = 2;
  localparam int LEAF3     = 3;
  localparam int UP        = 4;
  localparam int NUM_PORTS = 5;
  localparam int PTR_W     = 3;

  // First requester at or after ptr, wrapping modulo NUM_PORTS.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
    int   s;
    logic found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      s = int'(ptr) + k;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      if (!found && req[s]) begin
        rr_pick = PTR_W'(s);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/leaf_rtr_fifo.sv
// Per-port input FIFO. ready is registered and stays high while at least two
// entries are free, so the sender's one in-flight flit always fits.
module leaf_rtr_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              ready
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_next;
  logic              full, do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + 1'b1;
    else if (!do_push && do_pop) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= (count_next <= (AW+1)'(DEPTH - 2));
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/leaf_group_router.sv
// Group-level switch: four local NI ports plus one spine uplink, each with an
// input FIFO, routed on the flit header through per-output round-robin arbiters.
module leaf_group_router
  import leaf_rtr_pkg::*;
#(
  parameter logic [3:0] GROUP_ID   = 4'd6,
  parameter int         DATA_W     = 16,
  parameter int         NUM_LEAF   = 4,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_LEAF*DATA_W-1:0] l_data_in,
  input  logic [NUM_LEAF-1:0]        l_valid_in,
  output logic [NUM_LEAF-1:0]        l_ready_out,
  output logic [NUM_LEAF*DATA_W-1:0] l_data_out,
  output logic [NUM_LEAF-1:0]        l_valid_out,
  input  logic [DATA_W-1:0]          up_data_in,
  input  logic                       up_valid_in,
  output logic                       up_ready_out,
  output logic [DATA_W-1:0]          up_data_out,
  output logic                       up_valid_out,
  input  logic                       up_ready_in,
  output logic [7:0]                 drop_count
);
  logic [DATA_W-1:0]    in_data  [NUM_PORTS];
  logic [DATA_W-1:0]    head     [NUM_PORTS];
  logic [DATA_W-1:0]    out_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] req      [NUM_PORTS];
  logic [PTR_W-1:0]     gnt_idx  [NUM_PORTS];
  logic [PTR_W-1:0]     rr_ptr   [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_valid, pop, empty, rdy, gnt, out_valid;
  logic                 up_drop;

  for (genvar i = 0; i < NUM_LEAF; i++) begin : g_leaf
    assign in_data[i]                     = l_data_in[i*DATA_W +: DATA_W];
    assign in_valid[i]                    = l_valid_in[i];
    assign l_data_out[i*DATA_W +: DATA_W] = out_data[i];
    assign l_valid_out[i]                 = out_valid[i];
    assign l_ready_out[i]                 = rdy[i];
  end
  assign in_data[UP]  = up_data_in;
  assign in_valid[UP] = up_valid_in;
  assign up_data_out  = out_data[UP];
  assign up_valid_out = out_valid[UP];
  assign up_ready_out = rdy[UP];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
    leaf_rtr_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid[p]),
      .push_data (in_data[p]),
      .pop       (pop[p]),
      .head      (head[p]),
      .empty     (empty[p]),
      .ready     (rdy[p])
    );
  end

  // req[o][s]: head of input s wants output o. Foreign-group flits arriving
  // from the spine have nowhere to go and are discarded instead.
  always_comb begin
    up_drop = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) req[o] = '0;
    for (int s = 0; s < NUM_PORTS; s++) begin
      if (!empty[s]) begin
        if (head[s][GRP_MSB:GRP_LSB] == GROUP_ID) begin
          for (int o = 0; o < NUM_LEAF; o++)
            if (head[s][LEAF_MSB:LEAF_LSB] == 2'(o)) req[o][s] = 1'b1;
        end else if (s == UP) begin
          up_drop = 1'b1;
        end else begin
          req[UP][s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop     = '0;
    pop[UP] = up_drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_idx[o] = rr_pick(req[o], rr_ptr[o]);
      gnt[o]     = (|req[o]) && ((o != UP) || up_ready_in);
      for (int s = 0; s < NUM_PORTS; s++)
        if (gnt[o] && gnt_idx[o] == PTR_W'(s)) pop[s] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= '0;
      drop_count <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_data[o] <= '0;
        rr_ptr[o]   <= '0;
      end
    end else begin
      out_valid <= gnt;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (gnt[o]) begin
          out_data[o] <= head[gnt_idx[o]];
          rr_ptr[o]   <= (gnt_idx[o] == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx[o] + 1'b1;
        end
      end
      if (up_drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_leaf_group_router.sv
// Bench for leaf_group_router: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based behavioural model.
module tb_leaf_group_router;
  localparam int GID = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] l_data_in = '0;
  logic [3:0]  l_valid_in = '0;
  logic [3:0]  l_ready_out;
  logic [63:0] l_data_out;
  logic [3:0]  l_valid_out;
  logic [15:0] up_data_in = '0;
  logic        up_valid_in = 1'b0;
  logic        up_ready_out;
  logic [15:0] up_data_out;
  logic        up_valid_out;
  logic        up_ready_in = 1'b1;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: one queue per input, one priority pointer per output.
  logic [15:0] mq [5][$];
  int          m_ptr  [5];
  bit          e_valid[5];
  logic [15:0] e_data [5];
  bit          e_rdy  [5];
  int          e_drop;
  bit [4:0]    pr;

  leaf_group_router #(.GROUP_ID(4'(GID)), .DATA_W(16), .NUM_LEAF(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .l_data_in    (l_data_in),
    .l_valid_in   (l_valid_in),
    .l_ready_out  (l_ready_out),
    .l_data_out   (l_data_out),
    .l_valid_out  (l_valid_out),
    .up_data_in   (up_data_in),
    .up_valid_in  (up_valid_in),
    .up_ready_out (up_ready_out),
    .up_data_out  (up_data_out),
    .up_valid_out (up_valid_out),
    .up_ready_in  (up_ready_in),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 0..3 local leaf, 4 uplink, 5 discard.
  function automatic int dest_of(input logic [15:0] f, input int s);
    if (int'(f[15:12]) == GID) return int'(f[11:10]);
    if (s == 4) return 5;
    return 4;
  endfunction

  task automatic model_step();
    bit          popm[5];
    bit          vin [5];
    logic [15:0] din [5];
    bit          full;
    for (int s = 0; s < 4; s++) begin
      din[s] = l_data_in[s*16 +: 16];
      vin[s] = l_valid_in[s];
    end
    din[4] = up_data_in;
    vin[4] = up_valid_in;
    if (reset) begin
      for (int s = 0; s < 5; s++) begin
        mq[s].delete();
        m_ptr[s] = 0; e_valid[s] = 0; e_data[s] = '0; e_rdy[s] = 0;
      end
      e_drop = 0;
      return;
    end
    for (int s = 0; s < 5; s++) popm[s] = 0;
    for (int o = 0; o < 5; o++) begin
      e_valid[o] = 0;
      if (o == 4 && !up_ready_in) continue;
      for (int k = 0; k < 5; k++) begin
        int s;
        s = (m_ptr[o] + k) % 5;
        if (mq[s].size() > 0 && dest_of(mq[s][0], s) == o) begin
          e_valid[o] = 1;
          e_data[o]  = mq[s][0];
          popm[s]    = 1;
          m_ptr[o]   = (s + 1) % 5;
          break;
        end
      end
    end
    if (mq[4].size() > 0 && dest_of(mq[4][0], 4) == 5) begin
      popm[4] = 1;
      if (e_drop < 255) e_drop++;
    end
    for (int s = 0; s < 5; s++) begin
      full = (mq[s].size() == 4);
      if (vin[s]) chk("overflow", 64'(full), 64'd0);
      if (popm[s]) void'(mq[s].pop_front());
      if (vin[s] && !full) mq[s].push_back(din[s]);
      e_rdy[s] = (mq[s].size() <= 2);
    end
  endtask

  task automatic tick();
    logic [63:0] eld;
    logic [3:0]  elv;
    logic [4:0]  erd;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      eld[i*16 +: 16] = e_data[i];
      elv[i]          = e_valid[i];
    end
    for (int i = 0; i < 5; i++) erd[i] = e_rdy[i];
    chk("l_valid", 64'(l_valid_out), 64'(elv));
    chk("l_data", l_data_out, eld);
    chk("up_valid", 64'(up_valid_out), 64'(e_valid[4]));
    chk("up_data", 64'(up_data_out), 64'(e_data[4]));
    chk("drop", 64'(drop_count), 64'(e_drop));
    chk("ready", 64'({up_ready_out, l_ready_out}), 64'(erd));
    pr = {up_ready_out, l_ready_out};
  endtask

  task automatic drive(input int p, input logic [15:0] f);
    if (p == 4) begin
      up_valid_in = 1'b1;
      up_data_in  = f;
    end else begin
      l_valid_in[p]          = 1'b1;
      l_data_in[p*16 +: 16]  = f;
    end
  endtask

  task automatic idle_in();
    l_valid_in  = '0;
    up_valid_in = 1'b0;
  endtask

  initial begin
    int          sent;
    int          got;
    logic [15:0] f;

    // Reset
    reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'({up_valid_out, l_valid_out}), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_ready", 64'({up_ready_out, l_ready_out}), 64'h1f);

    // Local delivery, leaf0 -> leaf2
    drive(0, 16'h6A55); tick(); idle_in(); tick();
    chk("t1_valid", 64'({up_valid_out, l_valid_out}), 64'b00100);
    chk("t1_data", 64'(l_data_out[47:32]), 64'h6A55);

    // Uplink delivery, then held by up_ready_in
    drive(1, 16'h8C01); tick(); idle_in(); tick();
    chk("t2_up", 64'({up_valid_out, up_data_out}), 64'h18C01);
    up_ready_in = 1'b0;
    drive(1, 16'h8C01); tick(); idle_in();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t2_hold", 64'(up_valid_out), 64'd0);
    end
    up_ready_in = 1'b1;
    tick();
    chk("t2_release", 64'({up_valid_out, up_data_out}), 64'h18C01);

    // Contention for leaf1, back-to-back pairs
    drive(0, 16'h6400); drive(3, 16'h6401); tick();
    drive(0, 16'h6402); drive(3, 16'h6403); tick();
    chk("t3_first", 64'({l_valid_out, l_data_out[31:16]}), 64'h26400);
    idle_in();
    tick(); chk("t3_second", 64'({l_valid_out, l_data_out[31:16]}), 64'h26401);
    tick(); chk("t3_third", 64'({l_valid_out, l_data_out[31:16]}), 64'h26402);
    tick(); chk("t3_fourth", 64'({l_valid_out, l_data_out[31:16]}), 64'h26403);
    tick();

    // Uplink blocked while leaf2 streams, obeying ready
    up_ready_in = 1'b0;
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      if (sent < 4 && pr[2]) begin
        drive(2, 16'h9000 + 16'(sent));
        sent++;
      end
      tick();
      idle_in();
    end
    chk("t4_ready_low", 64'(l_ready_out[2]), 64'd0);
    up_ready_in = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (sent < 4 && pr[2]) begin
        drive(2, 16'h9000 + 16'(sent));
        sent++;
      end
      tick();
      idle_in();
      if (up_valid_out) begin
        chk("t4_order", 64'(up_data_out), 64'(16'h9000 + 16'(got)));
        got++;
      end
    end
    chk("t4_count", 64'(got), 64'd4);

    // Spine: foreign group dropped, own group delivered
    drive(4, 16'h5000); tick(); idle_in(); tick();
    chk("t5_novalid", 64'({up_valid_out, l_valid_out}), 64'd0);
    chk("t5_drop", 64'(drop_count), 64'd1);
    drive(4, 16'h6C00); tick(); idle_in(); tick();
    chk("t5_leaf3", 64'({l_valid_out, l_data_out[63:48]}), 64'h86C00);

    // Reset with flits queued
    up_ready_in = 1'b0;
    drive(1, 16'h9100); tick();
    drive(1, 16'h9101); tick();
    drive(1, 16'h9102); tick();
    idle_in();
    reset = 1'b1;
    tick();
    chk("t6_valid", 64'({up_valid_out, l_valid_out}), 64'd0);
    chk("t6_drop", 64'(drop_count), 64'd0);
    reset = 1'b0;
    up_ready_in = 1'b1;
    tick();
    chk("t6_ready", 64'({up_ready_out, l_ready_out}), 64'h1f);
    tick();
    chk("t6_flushed", 64'({up_valid_out, l_valid_out}), 64'd0);

    // Random traffic on all ports
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 5; p++) begin
        if (pr[p] && $urandom_range(0, 1) == 1) begin
          f = 16'($urandom);
          if ($urandom_range(0, 2) != 0) f[15:12] = 4'(GID);
          drive(p, f);
        end
      end
      up_ready_in = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 249) == 0);
      tick();
      idle_in();
      reset = 1'b0;
    end
    up_ready_in = 1'b1;
    for (int c = 0; c < 10; c++) tick();

    // drop_count saturation
    for (int c = 0; c < 300; c++) begin
      if (pr[4]) drive(4, 16'h1234);
      tick();
      idle_in();
    end
    tick();
    chk("t7_sat", 64'(drop_count), 64'd255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
